sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one SRAM-like memory port between the instruction-fetch requester (pc/ic) and the data requester (ex/mem).
//  Allows one outstanding transaction; a 3-state FSM sequences the transaction onto the shared port.
//  Data side has priority; a starvation counter guarantees fetch forward progress.
//  Sits between mycpu core fetch/data SRAM interfaces and the single external memory port.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width (strobe width = DATA_W/8)
//  MAX_STARVE  4   consecutive data grants while if_req pending before fetch is forced (>=1)
// PORTS
//  clk         in   1         clock; all logic on rising edge
//  rst         in   1         reset, asynchronous, active-low (0 = reset)
//  if_req      in   1         fetch request (read only), held until if_addr_ok
//  if_addr     in   ADDR_W    fetch address
//  if_addr_ok  out  1         fetch request accepted (1-cycle pulse)
//  if_data_ok  out  1         fetch read data valid (1-cycle pulse)
//  if_rdata    out  DATA_W    fetch read data
//  d_req       in   1         data request, held until d_addr_ok
//  d_wr        in   1         1 = store, 0 = load
//  d_wstrb     in   DATA_W/8  byte enables for stores
//  d_addr      in   ADDR_W    data address
//  d_wdata     in   DATA_W    store data
//  d_addr_ok   out  1         data request accepted (pulse)
//  d_data_ok   out  1         data response (load data / store done) (pulse)
//  d_rdata     out  DATA_W    load data
//  m_req       out  1         shared-port request
//  m_wr        out  1         shared-port write
//  m_wstrb     out  DATA_W/8  shared-port byte enables
//  m_addr      out  ADDR_W    shared-port address
//  m_wdata     out  DATA_W    shared-port write data
//  m_addr_ok   in   1         slave accepted request
//  m_data_ok   in   1         slave response valid
//  m_rdata     in   DATA_W    slave read data
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE, owner/addr/wdata/wstrb/wr regs=0, starve_cnt=0; every output 0.
//  FSM states: IDLE -> ADDR -> WAIT -> IDLE.
//   IDLE: if d_req or if_req, grant winner. *_addr_ok is combinational in this cycle for the winner only.
//         On grant, latch owner, addr, wr, wstrb, wdata; go to ADDR.
//         Fetch latches wr=0, wstrb=0, wdata=0.
//   ADDR: m_req=1, driven from latched regs, stable until m_addr_ok; on m_addr_ok go to WAIT.
//   WAIT: m_req=0; on m_data_ok pulse owner's *_data_ok (combinational, same cycle).
//         Owner's *_rdata = m_rdata in that cycle; go to IDLE.
//  Outside the response cycle, *_rdata = 0 and the non-owner's data_ok = 0.
//  m_data_ok is ignored in IDLE/ADDR. m_addr_ok is ignored outside ADDR.
//  Minimum latency: req cycle 0 -> addr_ok cycle 0 -> m_req cycle 1 -> data_ok cycle 2 at earliest.
//  Back-to-back transactions occupy at least 3 cycles each; IDLE re-arbitrates on the cycle after data_ok.
//  Arbitration: d_req wins over if_req, unless starve_cnt == MAX_STARVE and if_req=1, in which case fetch wins.
//  starve_cnt update, on each grant:
//   - data grant with if_req=1: +1, saturating at MAX_STARVE
//   - fetch grant: 0
//   - data grant with if_req=0: 0
//  m_wstrb = m_wr ? latched wstrb : 0 (loads never drive strobes).
//  Requester inputs are sampled only in the IDLE grant cycle; later changes have no effect on the transaction.
//  Reset mid-transaction: outputs drop to 0 immediately; in-flight response is discarded.
//   After release, any stale m_data_ok is ignored (FSM in IDLE). The slave must be reset together with this block.
// TESTING
//  T1 fetch only: if_req=1, if_addr=0xBFC00000 at c0; m_addr_ok=1 at c1; m_data_ok=1, m_rdata=0x3C010001 at c3
//     -> if_addr_ok c0; m_req=1 c1 only; if_data_ok=1, if_rdata=0x3C010001 at c3.
//  T2 simultaneous: if_req=d_req=1 (d_wr=0, d_addr=0x80001000) at c0 -> d_addr_ok c0;
//     if_addr_ok in first IDLE cycle after d_data_ok.
//  T3 starvation (MAX_STARVE=4): both requests held high, zero-wait slave -> grant order D,D,D,D,I,D,D,D,D,I.
//  T4 slave backpressure: m_addr_ok=0 for 5 cycles in ADDR
//     -> m_req, m_addr, m_wdata, m_wstrb constant for all 5 cycles; no extra addr_ok.
//  T5 strobes: d_wr=1, d_wstrb=4'b0001, d_wdata=0x000000AB -> m_wr=1, m_wstrb=0001;
//     then d_wr=0, d_wstrb=4'b1111 -> m_wr=0, m_wstrb=0000.
//  T6 reset in WAIT: rst=0 mid-cycle -> all outputs 0 before next edge;
//     m_data_ok=1 one cycle after release -> no if/d_data_ok.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like memory port between the fetch and data requesters.
// One outstanding transaction; data wins unless fetch has been starved MAX_STARVE times.
module sram_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_addr_ok,
    output logic                if_data_ok,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                d_req,
    input  logic                d_wr,
    input  logic [DATA_W/8-1:0] d_wstrb,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_addr_ok,
    output logic                d_data_ok,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                m_req,
    output logic                m_wr,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_addr_ok,
    input  logic                m_data_ok,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(MAX_STARVE + 1);

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StWait
    } state_e;

    state_e              state_q, state_d;
    logic                owner_if_q, owner_if_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_q, wr_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    starve_q, starve_d;

    logic starved;
    logic grant_if;
    logic grant_d;
    logic resp;

    assign starved  = (starve_q == CNT_W'(MAX_STARVE));
    assign grant_if = (state_q == StIdle) && if_req && (!d_req || starved);
    assign grant_d  = (state_q == StIdle) && d_req && !grant_if;
    assign resp     = (state_q == StWait) && m_data_ok;

    always_comb begin
        state_d    = state_q;
        owner_if_d = owner_if_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        wstrb_d    = wstrb_q;
        wdata_d    = wdata_q;
        starve_d   = starve_q;
        unique case (state_q)
            StIdle: begin
                if (grant_if) begin
                    state_d    = StAddr;
                    owner_if_d = 1'b1;
                    addr_d     = if_addr;
                    wr_d       = 1'b0;
                    wstrb_d    = '0;
                    wdata_d    = '0;
                    starve_d   = '0;
                end else if (grant_d) begin
                    state_d    = StAddr;
                    owner_if_d = 1'b0;
                    addr_d     = d_addr;
                    wr_d       = d_wr;
                    wstrb_d    = d_wstrb;
                    wdata_d    = d_wdata;
                    // Only consecutive data wins against a waiting fetch count as starvation.
                    if (!if_req) begin
                        starve_d = '0;
                    end else if (!starved) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end
            end
            StAddr: begin
                if (m_addr_ok) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (m_data_ok) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            owner_if_q <= 1'b0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_if_q <= owner_if_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            wstrb_q    <= wstrb_d;
            wdata_q    <= wdata_d;
            starve_q   <= starve_d;
        end
    end

    // Grants are gated by rst so a request held during reset never sees addr_ok.
    always_comb begin
        if_addr_ok = grant_if && rst;
        d_addr_ok  = grant_d && rst;
        if_data_ok = resp && owner_if_q;
        d_data_ok  = resp && !owner_if_q;
        if_rdata   = if_data_ok ? m_rdata : '0;
        d_rdata    = d_data_ok ? m_rdata : '0;
        m_req      = (state_q == StAddr);
        m_wr       = wr_q;
        m_wstrb    = wr_q ? wstrb_q : '0;
        m_addr     = addr_q;
        m_wdata    = wdata_q;
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized bench for sram_port_arbiter against a transaction-level reference model.
module tb_sram_port_arbiter;

    localparam int unsigned MAX_STARVE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_addr_ok, if_data_ok;
    logic [31:0] if_rdata;
    logic        d_req, d_wr;
    logic [3:0]  d_wstrb;
    logic [31:0] d_addr, d_wdata;
    logic        d_addr_ok, d_data_ok;
    logic [31:0] d_rdata;
    logic        m_req, m_wr;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;

    sram_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MAX_STARVE(MAX_STARVE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_addr_ok(if_addr_ok),
        .if_data_ok(if_data_ok),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_wstrb   (d_wstrb),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_addr_ok (d_addr_ok),
        .d_data_ok (d_data_ok),
        .d_rdata   (d_rdata),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_wstrb   (m_wstrb),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_addr_ok (m_addr_ok),
        .m_data_ok (m_data_ok),
        .m_rdata   (m_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one pending transaction, whether the slave took its address yet,
    // and how many data grants in a row have passed over a waiting fetch.
    bit          busy, sent, own_if;
    logic [31:0] e_addr, e_wdata;
    logic        e_wr;
    logic [3:0]  e_wstrb;
    int          starve;
    bit          if_acc, d_acc;
    logic [9:0]  glog;
    int          glog_n;

    bit          manual;
    int unsigned p_if, p_d, p_aok, p_dok;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " if_addr_ok"}, if_addr_ok, 0);
        chk({tag, " if_data_ok"}, if_data_ok, 0);
        chk({tag, " if_rdata"}, if_rdata, 0);
        chk({tag, " d_addr_ok"}, d_addr_ok, 0);
        chk({tag, " d_data_ok"}, d_data_ok, 0);
        chk({tag, " d_rdata"}, d_rdata, 0);
        chk({tag, " m_req"}, m_req, 0);
        chk({tag, " m_wr"}, m_wr, 0);
        chk({tag, " m_wstrb"}, m_wstrb, 0);
        chk({tag, " m_addr"}, m_addr, 0);
        chk({tag, " m_wdata"}, m_wdata, 0);
    endtask

    task automatic model_reset();
        busy   = 0;
        sent   = 0;
        own_if = 0;
        starve = 0;
    endtask

    task automatic rand_inputs();
        if (!if_req || if_acc) begin
            if_req  = ($urandom_range(99) < p_if);
            if_addr = $urandom;
        end
        if (!d_req || d_acc) begin
            d_req   = ($urandom_range(99) < p_d);
            d_wr    = 1'($urandom_range(1));
            d_wstrb = 4'($urandom);
            d_addr  = $urandom;
            d_wdata = $urandom;
        end
        m_addr_ok = ($urandom_range(99) < p_aok);
        m_data_ok = ($urandom_range(99) < p_dok);
        m_rdata   = $urandom;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic step();
        bit w_if, w_d, resp;
        @(negedge clk);
        w_if = 0;
        w_d  = 0;
        if (!busy) begin
            w_if = if_req && (!d_req || starve == MAX_STARVE);
            w_d  = d_req && !w_if;
        end
        resp = busy && sent && m_data_ok;
        chk("if_addr_ok", if_addr_ok, w_if);
        chk("d_addr_ok", d_addr_ok, w_d);
        chk("m_req", m_req, busy && !sent);
        if (busy && !sent) begin
            chk("m_addr", m_addr, e_addr);
            chk("m_wr", m_wr, e_wr);
            chk("m_wstrb", m_wstrb, e_wr ? e_wstrb : 4'h0);
            chk("m_wdata", m_wdata, e_wdata);
        end
        chk("if_data_ok", if_data_ok, resp && own_if);
        chk("d_data_ok", d_data_ok, resp && !own_if);
        chk("if_rdata", if_rdata, (resp && own_if) ? m_rdata : 32'h0);
        chk("d_rdata", d_rdata, (resp && !own_if) ? m_rdata : 32'h0);

        if_acc = w_if;
        d_acc  = w_d;
        if (w_if || w_d) begin
            busy    = 1;
            sent    = 0;
            own_if  = w_if;
            e_addr  = w_if ? if_addr : d_addr;
            e_wr    = w_d && d_wr;
            e_wstrb = w_d ? d_wstrb : 4'h0;
            e_wdata = w_d ? d_wdata : 32'h0;
            if (w_if || !if_req) starve = 0;
            else if (starve < MAX_STARVE) starve = starve + 1;
            if (glog_n < 10) begin
                glog = {glog[8:0], w_if};
                glog_n++;
            end
        end else if (busy && !sent && m_addr_ok) begin
            sent = 1;
        end else if (resp) begin
            busy = 0;
        end
        @(posedge clk);
        #1;
        if (!manual) rand_inputs();
    endtask

    task automatic drain();
        manual    = 1;
        if_req    = 0;
        d_req     = 0;
        m_addr_ok = 1;
        m_data_ok = 1;
        repeat (4) step();
        m_addr_ok = 0;
        m_data_ok = 0;
    endtask

    initial begin
        rst = 0;
        if_req = 0; if_addr = 0;
        d_req = 0; d_wr = 0; d_wstrb = 0; d_addr = 0; d_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
        manual = 1; glog = 0; glog_n = 10;
        if_acc = 0; d_acc = 0;
        e_addr = 0; e_wdata = 0; e_wr = 0; e_wstrb = 0;
        p_if = 50; p_d = 50; p_aok = 50; p_dok = 50;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1;

        // Fetch-only transaction with a one-cycle gap before the response.
        if_req = 1; if_addr = 32'hBFC0_0000;
        step();
        if_req = 0; m_addr_ok = 1;
        step();
        m_addr_ok = 0;
        step();
        m_data_ok = 1; m_rdata = 32'h3C01_0001;
        #1;
        chk("t1_if_rdata", if_rdata, 32'h3C01_0001);
        step();
        m_data_ok = 0;
        step();

        // Both requesters held high against a zero-wait slave: starvation ordering.
        if_req = 1; if_addr = 32'h1000_0000;
        d_req = 1; d_wr = 0; d_addr = 32'h8000_1000;
        m_addr_ok = 1; m_data_ok = 1;
        manual = 0; p_if = 100; p_d = 100; p_aok = 100; p_dok = 100;
        glog = 0; glog_n = 0;
        repeat (30) step();
        chk("t3_grant_count", glog_n, 10);
        chk("t3_grant_order", glog, 10'b0000100001);
        drain();

        // Store strobes pass through, load strobes are forced to zero.
        d_req = 1; d_wr = 1; d_wstrb = 4'b0001; d_wdata = 32'h0000_00AB; d_addr = 32'h8000_0040;
        step();
        d_req = 0;
        step();
        chk("t5_store_m_wr", m_wr, 1);
        chk("t5_store_m_wstrb", m_wstrb, 4'b0001);
        drain();
        d_req = 1; d_wr = 0; d_wstrb = 4'b1111; d_addr = 32'h8000_0044;
        step();
        d_req = 0;
        step();
        chk("t5_load_m_wr", m_wr, 0);
        chk("t5_load_m_wstrb", m_wstrb, 4'b0000);
        drain();

        // Slave backpressure while new requests with different payloads arrive.
        d_req = 1; d_wr = 1; d_wstrb = 4'b1100; d_addr = 32'h8000_2000; d_wdata = 32'hDEAD_BEEF;
        step();
        d_addr = 32'h8000_3000; d_wdata = 32'h1234_5678; d_wstrb = 4'b0011;
        if_req = 1; if_addr = 32'hBFC0_0100;
        repeat (5) step();
        m_addr_ok = 1;
        step();
        m_addr_ok = 0; m_data_ok = 1;
        step();
        m_data_ok = 0;
        step();
        drain();

        // Reset asserted mid-cycle while waiting for the response.
        if_req = 1; if_addr = 32'hBFC0_0200;
        step();
        if_req = 0; m_addr_ok = 1;
        step();
        m_addr_ok = 0;
        rst = 0; if_req = 1; d_req = 1;
        #1;
        chk_zero("t6_reset");
        model_reset();
        if_req = 0; d_req = 0;
        @(posedge clk);
        #1;
        rst = 1; m_data_ok = 1; m_rdata = 32'hCAFE_F00D;
        step();
        m_data_ok = 0;
        step();

        // Randomized traffic in several regimes.
        manual = 0; p_if = 50; p_d = 50; p_aok = 60; p_dok = 60;
        repeat (3000) step();
        p_aok = 10; p_dok = 30;
        repeat (1000) step();
        p_if = 90; p_d = 90; p_aok = 80; p_dok = 80;
        repeat (1000) step();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
